// File: rtl/hack_kbd_pkg.sv
// hack_kbd_pkg: shared types and constants for the Hack PS/2 keyboard front end.
//   - rx_state_e  : PS/2 frame receiver states
//   - dec_state_e : scan-code set 2 sequence decoder states
//   - KEY_*       : Hack key codes for non-printing keys
//   - SC_*        : scan-code prefixes and shift-key codes
//   - odd_parity_ok() : odd parity check over a data byte plus its parity bit
package hack_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    DEC_NORMAL,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK,
    DEC_SKIP
  } dec_state_e;

  localparam logic [15:0] KEY_NONE      = 16'd0;
  localparam logic [15:0] KEY_SPACE     = 16'd32;
  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;
  localparam logic [15:0] KEY_F2        = 16'd142;
  localparam logic [15:0] KEY_F3        = 16'd143;
  localparam logic [15:0] KEY_F4        = 16'd144;
  localparam logic [15:0] KEY_F5        = 16'd145;
  localparam logic [15:0] KEY_F6        = 16'd146;
  localparam logic [15:0] KEY_F7        = 16'd147;
  localparam logic [15:0] KEY_F8        = 16'd148;
  localparam logic [15:0] KEY_F9        = 16'd149;
  localparam logic [15:0] KEY_F10       = 16'd150;
  localparam logic [15:0] KEY_F11       = 16'd151;
  localparam logic [15:0] KEY_F12       = 16'd152;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // The Pause sequence is E1 followed by 7 more bytes; the counter runs 0..6.
  localparam logic [2:0] PAUSE_SKIP_LAST = 3'd6;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/hack_keyboard_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   clk_i        : system clock
//   rst_ni       : synchronous active-low reset
//   ps2_clk_i    : PS/2 clock pin (asynchronous)
//   ps2_data_i   : PS/2 data pin (asynchronous)
//   byte_o       : last correctly framed byte
//   byte_valid_o : one-cycle pulse when byte_o is updated
//   frame_err_o  : one-cycle pulse on a start, parity or stop error
// A frame is start(0), 8 data bits LSB first, odd parity, stop(1), each bit
// sampled on a falling edge of ps2_clk. A watchdog abandons a partial frame
// after TIMEOUT_CYCLES clocks without a falling edge.
module ps2_rx
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned     WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic            clk_s1_q, clk_s2_q, clk_s3_q;
  logic            dat_s1_q, dat_s2_q, dat_s3_q;
  logic            fall_q;
  rx_state_e       state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            valid_q;
  logic            err_q;
  logic [WD_W-1:0] wd_cnt_q;

  // Two sync stages, then one more stage on both pins: the clock copy
  // forms the edge register and the data copy stays aligned with fall_q.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      dat_s1_q <= 1'b0;
      dat_s2_q <= 1'b0;
      dat_s3_q <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      dat_s3_q <= dat_s2_q;
      fall_q   <= clk_s3_q & ~clk_s2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (fall_q) begin
        wd_cnt_q <= '0;
      end else if (wd_cnt_q != WD_MAX) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end

      if (fall_q) begin
        case (state_q)
          RX_IDLE: begin
            if (dat_s3_q) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q <= {dat_s3_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= RX_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          RX_PARITY: begin
            if (odd_parity_ok(shift_q, dat_s3_q)) begin
              state_q <= RX_STOP;
            end else begin
              err_q   <= 1'b1;
              state_q <= RX_IDLE;
            end
          end
          RX_STOP: begin
            if (dat_s3_q) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end else if (state_q != RX_IDLE && wd_cnt_q == WD_MAX) begin
        state_q <= RX_IDLE;
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/hack_keyboard.sv
// hack_keyboard: PS/2 keyboard front end producing the Hack keyboard word.
//   TIMEOUT_CYCLES : clk cycles without a PS/2 falling edge before a partial
//                    frame is discarded
//   clk            : system clock
//   reset_n        : synchronous active-low reset
//   ps2_clk        : PS/2 clock pin (asynchronous)
//   ps2_data       : PS/2 data pin (asynchronous)
//   kbOut          : Hack key code of the held key, 0 when none (Memory.kbIn)
//   byteValid      : one-cycle pulse per correctly framed byte
//   frameErr       : one-cycle pulse on a start, parity or stop error
// Build option: define HACK_KBD_SHIFT_EN to track left/right shift, giving
// lowercase letters unshifted and US symbols on shifted digits.
module hack_keyboard
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kbOut,
  output logic        byteValid,
  output logic        frameErr
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;

  dec_state_e  dec_state_q;
  logic [2:0]  skip_cnt_q;
  logic [15:0] kb_q;

  logic        ext;
  logic        is_letter, is_digit, is_kp;
  logic [4:0]  idx;
  logic [15:0] fixed_key;
  logic [15:0] letter_base;
  logic [15:0] digit_key;
  logic [15:0] map_key;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  assign ext = (dec_state_q == DEC_EXT) || (dec_state_q == DEC_EXT_BRK);

  // Scan-code classification: letters and digits yield an index so the
  // shift-dependent base can be applied afterwards.
  always_comb begin
    is_letter = 1'b0;
    is_digit  = 1'b0;
    is_kp     = 1'b0;
    idx       = '0;
    fixed_key = KEY_NONE;
    if (ext) begin
      case (rx_byte)
        8'h6B:   fixed_key = KEY_LEFT;
        8'h75:   fixed_key = KEY_UP;
        8'h74:   fixed_key = KEY_RIGHT;
        8'h72:   fixed_key = KEY_DOWN;
        8'h6C:   fixed_key = KEY_HOME;
        8'h69:   fixed_key = KEY_END;
        8'h7D:   fixed_key = KEY_PGUP;
        8'h7A:   fixed_key = KEY_PGDN;
        8'h70:   fixed_key = KEY_INSERT;
        8'h71:   fixed_key = KEY_DELETE;
        default: fixed_key = KEY_NONE;
      endcase
    end else begin
      case (rx_byte)
        8'h1C: begin is_letter = 1'b1; idx = 5'd0;  end
        8'h32: begin is_letter = 1'b1; idx = 5'd1;  end
        8'h21: begin is_letter = 1'b1; idx = 5'd2;  end
        8'h23: begin is_letter = 1'b1; idx = 5'd3;  end
        8'h24: begin is_letter = 1'b1; idx = 5'd4;  end
        8'h2B: begin is_letter = 1'b1; idx = 5'd5;  end
        8'h34: begin is_letter = 1'b1; idx = 5'd6;  end
        8'h33: begin is_letter = 1'b1; idx = 5'd7;  end
        8'h43: begin is_letter = 1'b1; idx = 5'd8;  end
        8'h3B: begin is_letter = 1'b1; idx = 5'd9;  end
        8'h42: begin is_letter = 1'b1; idx = 5'd10; end
        8'h4B: begin is_letter = 1'b1; idx = 5'd11; end
        8'h3A: begin is_letter = 1'b1; idx = 5'd12; end
        8'h31: begin is_letter = 1'b1; idx = 5'd13; end
        8'h44: begin is_letter = 1'b1; idx = 5'd14; end
        8'h4D: begin is_letter = 1'b1; idx = 5'd15; end
        8'h15: begin is_letter = 1'b1; idx = 5'd16; end
        8'h2D: begin is_letter = 1'b1; idx = 5'd17; end
        8'h1B: begin is_letter = 1'b1; idx = 5'd18; end
        8'h2C: begin is_letter = 1'b1; idx = 5'd19; end
        8'h3C: begin is_letter = 1'b1; idx = 5'd20; end
        8'h2A: begin is_letter = 1'b1; idx = 5'd21; end
        8'h1D: begin is_letter = 1'b1; idx = 5'd22; end
        8'h22: begin is_letter = 1'b1; idx = 5'd23; end
        8'h35: begin is_letter = 1'b1; idx = 5'd24; end
        8'h1A: begin is_letter = 1'b1; idx = 5'd25; end
        8'h45: begin is_digit = 1'b1; idx = 5'd0; end
        8'h16: begin is_digit = 1'b1; idx = 5'd1; end
        8'h1E: begin is_digit = 1'b1; idx = 5'd2; end
        8'h26: begin is_digit = 1'b1; idx = 5'd3; end
        8'h25: begin is_digit = 1'b1; idx = 5'd4; end
        8'h2E: begin is_digit = 1'b1; idx = 5'd5; end
        8'h36: begin is_digit = 1'b1; idx = 5'd6; end
        8'h3D: begin is_digit = 1'b1; idx = 5'd7; end
        8'h3E: begin is_digit = 1'b1; idx = 5'd8; end
        8'h46: begin is_digit = 1'b1; idx = 5'd9; end
        // Keypad digits (no E0 prefix) always give plain digits.
        8'h70: begin is_kp = 1'b1; idx = 5'd0; end
        8'h69: begin is_kp = 1'b1; idx = 5'd1; end
        8'h72: begin is_kp = 1'b1; idx = 5'd2; end
        8'h7A: begin is_kp = 1'b1; idx = 5'd3; end
        8'h6B: begin is_kp = 1'b1; idx = 5'd4; end
        8'h73: begin is_kp = 1'b1; idx = 5'd5; end
        8'h74: begin is_kp = 1'b1; idx = 5'd6; end
        8'h6C: begin is_kp = 1'b1; idx = 5'd7; end
        8'h75: begin is_kp = 1'b1; idx = 5'd8; end
        8'h7D: begin is_kp = 1'b1; idx = 5'd9; end
        8'h29: fixed_key = KEY_SPACE;
        8'h5A: fixed_key = KEY_NEWLINE;
        8'h66: fixed_key = KEY_BACKSPACE;
        8'h76: fixed_key = KEY_ESC;
        8'h05: fixed_key = KEY_F1;
        8'h06: fixed_key = KEY_F2;
        8'h04: fixed_key = KEY_F3;
        8'h0C: fixed_key = KEY_F4;
        8'h03: fixed_key = KEY_F5;
        8'h0B: fixed_key = KEY_F6;
        8'h83: fixed_key = KEY_F7;
        8'h0A: fixed_key = KEY_F8;
        8'h01: fixed_key = KEY_F9;
        8'h09: fixed_key = KEY_F10;
        8'h78: fixed_key = KEY_F11;
        8'h07: fixed_key = KEY_F12;
        // Shift keys never produce a key code of their own.
        SC_LSHIFT, SC_RSHIFT: fixed_key = KEY_NONE;
        default: fixed_key = KEY_NONE;
      endcase
    end
  end

`ifdef HACK_KBD_SHIFT_EN
  logic        lshift_q, rshift_q;
  logic        shift_held;
  logic [15:0] shift_sym;

  assign shift_held = lshift_q | rshift_q;

  always_comb begin
    case (idx)
      5'd0:    shift_sym = 16'd41;  // )
      5'd1:    shift_sym = 16'd33;  // !
      5'd2:    shift_sym = 16'd64;  // @
      5'd3:    shift_sym = 16'd35;  // #
      5'd4:    shift_sym = 16'd36;  // $
      5'd5:    shift_sym = 16'd37;  // %
      5'd6:    shift_sym = 16'd94;  // ^
      5'd7:    shift_sym = 16'd38;  // &
      5'd8:    shift_sym = 16'd42;  // *
      5'd9:    shift_sym = 16'd40;  // (
      default: shift_sym = KEY_NONE;
    endcase
  end

  assign letter_base = shift_held ? 16'd65 : 16'd97;
  assign digit_key   = shift_held ? shift_sym : (16'd48 + {11'd0, idx});
`else
  assign letter_base = 16'd65;
  assign digit_key   = 16'd48 + {11'd0, idx};
`endif

  always_comb begin
    map_key = fixed_key;
    if (is_letter) begin
      map_key = letter_base + {11'd0, idx};
    end else if (is_kp) begin
      map_key = 16'd48 + {11'd0, idx};
    end else if (is_digit) begin
      map_key = digit_key;
    end
  end

  // Decoder: kbOut is registered here, one cycle after byteValid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_state_q <= DEC_NORMAL;
      skip_cnt_q  <= '0;
      kb_q        <= KEY_NONE;
`ifdef HACK_KBD_SHIFT_EN
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
`endif
    end else if (rx_valid) begin
      case (dec_state_q)
        DEC_NORMAL, DEC_EXT: begin
          if (rx_byte == SC_EXT) begin
            dec_state_q <= DEC_EXT;
          end else if (rx_byte == SC_BRK) begin
            dec_state_q <= (dec_state_q == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
          end else if (rx_byte == SC_PAUSE) begin
            dec_state_q <= DEC_SKIP;
            skip_cnt_q  <= '0;
          end else begin
            dec_state_q <= DEC_NORMAL;
            if (map_key != KEY_NONE) begin
              kb_q <= map_key;
            end
`ifdef HACK_KBD_SHIFT_EN
            if (dec_state_q == DEC_NORMAL && rx_byte == SC_LSHIFT) lshift_q <= 1'b1;
            if (dec_state_q == DEC_NORMAL && rx_byte == SC_RSHIFT) rshift_q <= 1'b1;
`endif
          end
        end
        DEC_BRK, DEC_EXT_BRK: begin
          dec_state_q <= DEC_NORMAL;
          if (map_key == kb_q) begin
            kb_q <= KEY_NONE;
          end
`ifdef HACK_KBD_SHIFT_EN
          if (dec_state_q == DEC_BRK && rx_byte == SC_LSHIFT) lshift_q <= 1'b0;
          if (dec_state_q == DEC_BRK && rx_byte == SC_RSHIFT) rshift_q <= 1'b0;
`endif
        end
        DEC_SKIP: begin
          if (skip_cnt_q == PAUSE_SKIP_LAST) begin
            dec_state_q <= DEC_NORMAL;
          end else begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
          end
        end
        default: dec_state_q <= DEC_NORMAL;
      endcase
    end
  end

  assign kbOut     = kb_q;
  assign byteValid = rx_valid;
  assign frameErr  = rx_err;

endmodule

// File: tb/tb_hack_keyboard.sv
module tb_hack_keyboard;

  localparam int unsigned TB_TIMEOUT = 1000;

`ifdef HACK_KBD_SHIFT_EN
  localparam logic [15:0] A_KEY  = 16'd97;
  localparam logic [15:0] B_KEY  = 16'd98;
  localparam logic [15:0] SH_ONE = 16'd33;
`else
  localparam logic [15:0] A_KEY  = 16'd65;
  localparam logic [15:0] B_KEY  = 16'd66;
  localparam logic [15:0] SH_ONE = 16'd49;
`endif

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] kbOut;
  logic        byteValid;
  logic        frameErr;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  sc;
    logic [15:0] kb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  hack_keyboard #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbOut    (kbOut),
    .byteValid(byteValid),
    .frameErr (frameErr)
  );

  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(50);
    ps2_clk = 1'b0;
    cycles(100);
    ps2_clk = 1'b1;
    cycles(50);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cycles(100);
  endtask

  // Queue the expected kbOut after this byte, then transmit it.
  task automatic key(input logic [7:0] sc, input logic [15:0] kb);
    exp_t e;
    e.is_err = 1'b0;
    e.sc     = sc;
    e.kb     = kb;
    exp_q.push_back(e);
    send_frame(sc, 1'b0);
  endtask

  task automatic expect_err(input logic [7:0] sc, input logic [15:0] kb);
    exp_t e;
    e.is_err = 1'b1;
    e.sc     = sc;
    e.kb     = kb;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one scoreboard entry per byteValid / frameErr pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (byteValid === 1'b1 || frameErr === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: byteValid=%0b frameErr=%0b, required no event",
                   byteValid, frameErr);
        end else begin
          e = exp_q.pop_front();
          check16($sformatf("event_kind_%02h", e.sc), {15'd0, frameErr}, {15'd0, e.is_err});
          if (byteValid === 1'b1) begin
            @(negedge clk);
            check16($sformatf("kbOut_after_%02h", e.sc), kbOut, e.kb);
          end else begin
            check16($sformatf("kbOut_on_err_%02h", e.sc), kbOut, e.kb);
          end
        end
      end
    end
  end

  initial begin : guard
    repeat (95000) @(posedge clk);
    $display("FAIL time_limit: simulation exceeded 95000 cycles, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    cycles(5);
    check16("reset_kbOut", kbOut, 16'd0);
    check16("reset_byteValid", {15'd0, byteValid}, 16'd0);
    check16("reset_frameErr", {15'd0, frameErr}, 16'd0);
    reset_n = 1'b1;
    cycles(20);

    // Even parity: parity error, then the stop bit (1) seen in idle.
    expect_err(8'h1C, 16'd0);
    expect_err(8'h1C, 16'd0);
    send_frame(8'h1C, 1'b1);

    key(8'h1C, A_KEY);
    key(8'hF0, A_KEY);
    key(8'h1C, 16'd0);

    key(8'hE0, 16'd0);
    key(8'h6B, 16'd130);
    key(8'hE0, 16'd130);
    key(8'hF0, 16'd130);
    key(8'h6B, 16'd0);
    key(8'h6B, 16'd52);

    // Partial frame abandoned by the watchdog.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cycles(TB_TIMEOUT + 10);
    key(8'h29, 16'd32);

    key(8'h1C, A_KEY);
    key(8'h32, B_KEY);
    key(8'hF0, B_KEY);
    key(8'h1C, B_KEY);
    key(8'hF0, B_KEY);
    key(8'h32, 16'd0);

    key(8'hE1, 16'd0);
    key(8'h14, 16'd0);
    key(8'h77, 16'd0);
    key(8'hE1, 16'd0);
    key(8'hF0, 16'd0);
    key(8'h14, 16'd0);
    key(8'hF0, 16'd0);
    key(8'h77, 16'd0);
    key(8'h5A, 16'd128);

    key(8'h12, 16'd128);
    key(8'h16, SH_ONE);
    key(8'hF0, SH_ONE);
    key(8'h12, SH_ONE);
    key(8'h16, 16'd49);

    // Reset while bit 4 of a frame is on the wire.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cycles(50);
    ps2_clk = 1'b0;
    cycles(20);
    reset_n = 1'b0;
    cycles(5);
    reset_n = 1'b1;
    cycles(75);
    ps2_clk = 1'b1;
    cycles(50);
    check16("kbOut_after_midframe_reset", kbOut, 16'd0);
    cycles(300);
    key(8'h1C, A_KEY);

    cycles(500);
    check16("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_keyboard.md
# hack_keyboard

PS/2 keyboard front end for the Hack platform. It receives serial PS/2 frames, decodes scan-code set 2 make, break and extended sequences, and holds the Hack key code of the currently pressed key. Its output drives `Memory.kbIn`, which the CPU reads at address 0x6000. It is the producer side of the keyboard word that `Memory` only consumes.

## Interface
- `TIMEOUT_CYCLES`, default 32000: `clk` cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 32 MHz).
- `clk` in 1: system clock, the same 32 MHz Hack clock as `Memory`.
- `reset_n` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: PS/2 data pin, asynchronous to `clk`.
- `kbOut` out 16: Hack key code of the held key; 0 when no key is held. Connects to `Memory.kbIn`.
- `byteValid` out 1: one-cycle pulse when a correctly framed byte is accepted.
- `frameErr` out 1: one-cycle pulse on a start, parity or stop error.

## Operation
- **Input synchronisation:** both pins pass through 2-FF synchronisers. A falling edge of `ps2_clk` is detected on the synchronised signal, and `ps2_data` is sampled on that edge.
- **Receiver FSM:** states IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - IDLE with a sampled 1 is not a start bit: stay in IDLE, `frameErr`=1.
  - Parity must be odd over data plus parity bit. Stop must be 1. Either failure pulses `frameErr`, drops the byte and returns to IDLE.
- **Watchdog:** counter cleared on every detected edge. If it reaches `TIMEOUT_CYCLES` in any state other than IDLE, the FSM returns to IDLE with no error pulse. The counter saturates.
- **Decoder FSM** (per accepted byte): states NORMAL, EXT, BRK, EXT_BRK, SKIP.
  - 0xE0 → EXT. 0xF0 → BRK from NORMAL, or EXT_BRK from EXT.
  - 0xE1 → SKIP, which discards the next 7 bytes (Pause sequence) using a 3-bit counter, then returns to NORMAL.
  - Any other byte is a code: look up its Hack key, then return to NORMAL.
- **Make code:** a mapped key loads `kbOut`. An unmapped key leaves `kbOut` unchanged. A typematic repeat of the same key leaves `kbOut` unchanged.
- **Break code:** if the released key equals the current `kbOut`, `kbOut`←0. Otherwise no change.
- **Key map** (Hack codes):
  - letters 65–90; digits 48–57; space 32
  - Enter 128, Backspace 129
  - Left 130, Up 131, Right 132, Down 133 (E0 prefix)
  - Home 134, End 135, PgUp 136, PgDn 137, Ins 138, Del 139 (E0 prefix)
  - Esc 140, F1–F12 141–152
  - Everything else is unmapped.
- **Reset:** `reset_n`=0 on a `clk` edge clears all FSMs, counters, synchronisers, `kbOut`, `byteValid` and `frameErr` to 0/IDLE/NORMAL. This applies equally in the middle of a frame; the bits already received are lost.

## Timing
- Edge detect: 3 `clk` cycles after the pin transition (2 sync stages plus the edge register).
- `byteValid` asserts the cycle after the stop bit is sampled.
- `kbOut` updates the cycle after `byteValid` (registered lookup). Total is 5 cycles from the stop-bit falling edge on the pin.
- `frameErr` asserts the cycle after the offending bit is sampled.
- A break of one key and a make of another never occur in the same cycle; bytes are strictly sequential.
- The bench drives PS/2 bits with a period of at least 200 `clk` cycles.

## Configuration
- `HACK_KBD_SHIFT_EN` defined:
  - Decoder tracks the left (0x12) and right (0x59) shift keys independently, via make and break. Shift codes are never output.
  - Unshifted letters → 97–122. Shifted letters → 65–90.
  - Shifted digits → US symbols: 1→33 `!`, 2→64 `@`, …, 0→41 `)`.
- Undefined:
  - Shift codes are treated as unmapped.
  - Letters always produce 65–90; digits always produce 48–57.

## Structure
- Package `hack_kbd_pkg`: receiver and decoder state enums, the Hack key-code constants (`KEY_NEWLINE`=128 … `KEY_F12`=152), and scan-code constants (`SC_EXT`=0xE0, `SC_BRK`=0xF0, `SC_PAUSE`=0xE1).
- Sub-module `ps2_rx`: synchronisers, edge detect, receiver FSM and watchdog. Outputs a byte plus `byteValid` and `frameErr`.
- `hack_keyboard` contains the decoder FSM, the key map and the shift state.

## Test plan
- Frame 0x1C → `byteValid` pulse, `kbOut`=65 (97 with the macro). Then F0,1C → `kbOut`=0.
- E0,6B → `kbOut`=130. Then E0,F0,6B → 0. Bare 6B (keypad 4) → 52.
- Frame 0x1C with even parity → `frameErr` pulse, no `byteValid`, `kbOut` stays 0.
- 5 bits of a frame, idle for `TIMEOUT_CYCLES`+10, then a full frame 0x29 → no `frameErr`, `kbOut`=32.
- 1C, 32, then F0,1C → `kbOut`=66. Then F0,32 → 0. E1 plus 7 Pause bytes, then 5A → 128.
- With `HACK_KBD_SHIFT_EN`: 12, 16 → 33. Then F0,12 and 16 → 49. Separately, `reset_n` low during bit 4 of a frame, then a clean 0x1C → 97.
